// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared types and constants for the branch resolve unit
//
// Purpose: the in-flight queue entry layout, the recovery state encoding and
// the PC width used by branch_resolve_unit and bru_pred_fifo.
// Ports: none (package).

package branch_resolve_unit_pkg;

  localparam int PC_W = 32;

  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } bru_state_e;

  typedef struct packed {
    logic            pred;
    logic [PC_W-1:0] pcplus4;
    logic [PC_W-1:0] target;
  } bru_entry_t;

endpackage

// File: rtl/bru_pred_fifo.sv
// rtl/bru_pred_fifo.sv - circular buffer holding in-flight branch predictions
//
// Purpose: DEPTH-entry FIFO of bru_entry_t with a synchronous clear.
// Ports:
//   Clock, Reset     rising-edge clock, synchronous active-high reset
//   i_push, i_wdata  write request and entry (ignored when full)
//   i_pop            read request (ignored when empty)
//   i_clear          empty the queue; wins over push and pop
//   o_rdata          head entry (valid when !o_empty)
//   o_full, o_empty  occupancy flags
//   o_count          occupancy, 0..DEPTH

import branch_resolve_unit_pkg::*;

module bru_pred_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_clear,
  input  bru_entry_t             i_wdata,
  output bru_entry_t             o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  bru_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge Clock) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge Clock) begin
    if (Reset || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves predicted branches in EX and raises mispredict flushes
//
// Purpose: queues each ID-stage prediction, checks it against the EX outcome,
// flushes with a corrected PC on mismatch, trains the predictor and keeps
// accuracy statistics.
// Ports:
//   Clock, Reset                    rising-edge clock, synchronous active-high reset
//   Stall                           pipeline hold, blocks queue push and pop
//   BranchInstructExists_ID         branch in ID; Prediction_ID, PCPlus4_ID, BranchTarget_ID describe it
//   BranchInstructExists_EX         branch resolving in EX; BranchTaken_EX is its outcome
//   Flush, RedirectPC               mispredict flush and corrected fetch PC
//   UpdateValid, UpdateTaken        predictor training strobe and outcome
//   BranchCount, MispredictCount    saturating statistics
//   Overflow, Underflow             sticky queue error flags

import branch_resolve_unit_pkg::*;

module branch_resolve_unit #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CW           = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Stall,
  input  logic            BranchInstructExists_ID,
  input  logic            Prediction_ID,
  input  logic [PC_W-1:0] PCPlus4_ID,
  input  logic [PC_W-1:0] BranchTarget_ID,
  input  logic            BranchInstructExists_EX,
  input  logic            BranchTaken_EX,
  output logic            Flush,
  output logic [PC_W-1:0] RedirectPC,
  output logic            UpdateValid,
  output logic            UpdateTaken,
  output logic [CW-1:0]   BranchCount,
  output logic [CW-1:0]   MispredictCount,
  output logic            Overflow,
  output logic            Underflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  bru_state_e       r_state;
  bru_state_e       w_state_nxt;
  logic [FCW-1:0]   r_cnt;
  logic [FCW-1:0]   w_cnt_nxt;

  logic [PC_W-1:0]  r_redirect_pc;
  logic             r_update_valid;
  logic             r_update_taken;
  logic [CW-1:0]    r_branch_count;
  logic [CW-1:0]    r_mispredict_count;
  logic             r_overflow;
  logic             r_underflow;

  bru_entry_t       w_wdata;
  bru_entry_t       w_head;
  logic             w_q_full;
  logic             w_q_empty;
  logic [AW:0]      w_q_count;

  logic             w_push_req;
  logic             w_resolve;
  logic             w_head_pred;
  logic             w_mismatch;
  logic             w_flush_start;
  logic             w_overflow_evt;
  logic             w_underflow_evt;

  assign w_wdata    = '{pred: Prediction_ID, pcplus4: PCPlus4_ID, target: BranchTarget_ID};
  assign w_push_req = !Stall && BranchInstructExists_ID && (r_state == NORMAL);
  assign w_resolve  = !Stall && BranchInstructExists_EX;

  // An empty queue has no prediction to offer, so it counts as not-taken.
  assign w_head_pred     = w_q_empty ? 1'b0 : w_head.pred;
  assign w_mismatch      = w_resolve && (w_head_pred != BranchTaken_EX);
  assign w_flush_start   = w_mismatch && !w_q_empty && (r_state == NORMAL);
  assign w_overflow_evt  = w_push_req && w_q_full;
  // During RECOVER the queue was just cleared on purpose, so that is not an underflow.
  assign w_underflow_evt = w_resolve && (w_q_count == '0) && (r_state == NORMAL);

  bru_pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_push  (w_push_req),
    .i_pop   (w_resolve),
    .i_clear (w_flush_start),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= NORMAL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The recovery countdown freezes under Stall so the flush outlasts the hold.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    Flush       = 1'b0;
    case (r_state)
      NORMAL: begin
        if (w_flush_start) begin
          w_state_nxt = RECOVER;
          w_cnt_nxt   = FCW'(FLUSH_CYCLES - 1);
        end
      end
      RECOVER: begin
        Flush = 1'b1;
        if (!Stall) begin
          if (r_cnt == '0) begin
            w_state_nxt = NORMAL;
          end else begin
            w_cnt_nxt = r_cnt - FCW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = NORMAL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_redirect_pc      <= '0;
      r_update_valid     <= 1'b0;
      r_update_taken     <= 1'b0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
      r_overflow         <= 1'b0;
      r_underflow        <= 1'b0;
    end else begin
      r_update_valid <= w_resolve;
      r_update_taken <= w_resolve && BranchTaken_EX;
      if (w_resolve && (r_branch_count != '1)) begin
        r_branch_count <= r_branch_count + CW'(1);
      end
      if (w_mismatch && (r_mispredict_count != '1)) begin
        r_mispredict_count <= r_mispredict_count + CW'(1);
      end
      if (w_flush_start) begin
        r_redirect_pc <= BranchTaken_EX ? w_head.target : w_head.pcplus4;
      end
      if (w_overflow_evt) begin
        r_overflow <= 1'b1;
      end
      if (w_underflow_evt) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign RedirectPC      = r_redirect_pc;
  assign UpdateValid     = r_update_valid;
  assign UpdateTaken     = r_update_taken;
  assign BranchCount     = r_branch_count;
  assign MispredictCount = r_mispredict_count;
  assign Overflow        = r_overflow;
  assign Underflow       = r_underflow;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit

module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int FLUSH_CYCLES = 2;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        BranchInstructExists_ID;
  logic        Prediction_ID;
  logic [31:0] PCPlus4_ID;
  logic [31:0] BranchTarget_ID;
  logic        BranchInstructExists_EX;
  logic        BranchTaken_EX;
  logic        Flush;
  logic [31:0] RedirectPC;
  logic        UpdateValid;
  logic        UpdateTaken;
  logic [15:0] BranchCount;
  logic [15:0] MispredictCount;
  logic        Overflow;
  logic        Underflow;

  branch_resolve_unit #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CW(16)) u_dut (
    .Clock                   (Clock),
    .Reset                   (Reset),
    .Stall                   (Stall),
    .BranchInstructExists_ID (BranchInstructExists_ID),
    .Prediction_ID           (Prediction_ID),
    .PCPlus4_ID              (PCPlus4_ID),
    .BranchTarget_ID         (BranchTarget_ID),
    .BranchInstructExists_EX (BranchInstructExists_EX),
    .BranchTaken_EX          (BranchTaken_EX),
    .Flush                   (Flush),
    .RedirectPC              (RedirectPC),
    .UpdateValid             (UpdateValid),
    .UpdateTaken             (UpdateTaken),
    .BranchCount             (BranchCount),
    .MispredictCount         (MispredictCount),
    .Overflow                (Overflow),
    .Underflow               (Underflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit          pred;
    logic [31:0] pc4;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    bit uv;
    bit ut;
  } exp_t;

  ent_t        mq[$];
  exp_t        exp_q[$];
  bit          m_rec;
  int          m_cnt;
  logic [31:0] m_redir;
  logic [15:0] m_bc;
  logic [15:0] m_mc;
  bit          m_ovf;
  bit          m_udf;

  int n_checks = 0;
  int n_fail   = 0;
  int flush_seen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model predicts the outcome, the scoreboard holds
  // the training expectation until the registered outputs appear.
  task automatic drive(input bit rst, input bit stall, input bit idv, input bit pred,
                       input logic [31:0] pc4, input logic [31:0] tgt,
                       input bit exv, input bit taken);
    exp_t e;
    ent_t h;
    bit   had;
    bit   mis;
    bit   fs;
    int   sz;
    Reset = rst; Stall = stall;
    BranchInstructExists_ID = idv; Prediction_ID = pred;
    PCPlus4_ID = pc4; BranchTarget_ID = tgt;
    BranchInstructExists_EX = exv; BranchTaken_EX = taken;
    e.uv = 1'b0; e.ut = 1'b0;
    if (rst) begin
      mq.delete(); m_rec = 0; m_cnt = 0; m_redir = '0;
      m_bc = '0; m_mc = '0; m_ovf = 0; m_udf = 0;
    end else begin
      fs = 0; had = 0;
      h.pred = 0; h.pc4 = '0; h.tgt = '0;
      sz = mq.size();
      if (!stall && exv) begin
        had = (sz > 0);
        if (had) h = mq[0];
        mis = (h.pred != taken);
        e.uv = 1'b1; e.ut = taken;
        if (m_bc != 16'hffff) m_bc++;
        if (mis && m_mc != 16'hffff) m_mc++;
        if (!had && !m_rec) m_udf = 1;
        if (mis && had && !m_rec) begin
          fs = 1;
          m_redir = taken ? h.tgt : h.pc4;
        end
        if (had) void'(mq.pop_front());
      end
      if (!stall && idv && !m_rec) begin
        if (sz == DEPTH) m_ovf = 1;
        else if (!fs) mq.push_back('{pred, pc4, tgt});
      end
      if (fs) begin
        mq.delete();
        m_rec = 1;
        m_cnt = FLUSH_CYCLES - 1;
      end else if (m_rec && !stall) begin
        if (m_cnt == 0) m_rec = 0;
        else m_cnt--;
      end
    end
    exp_q.push_back(e);
    @(posedge Clock);
    #1;
    e = exp_q.pop_front();
    check_eq("update_valid", {31'd0, UpdateValid}, {31'd0, e.uv});
    check_eq("update_taken", {31'd0, UpdateTaken}, {31'd0, e.ut});
    check_eq("flush",        {31'd0, Flush},       {31'd0, m_rec});
    check_eq("redirect_pc",  RedirectPC,           m_redir);
    check_eq("branch_count", {16'd0, BranchCount}, {16'd0, m_bc});
    check_eq("mispred_count",{16'd0, MispredictCount}, {16'd0, m_mc});
    check_eq("overflow",     {31'd0, Overflow},    {31'd0, m_ovf});
    check_eq("underflow",    {31'd0, Underflow},   {31'd0, m_udf});
    if (Flush) flush_seen++;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, '0, '0, 0, 0);
  endtask

  initial begin
    bit preds[11];

    drive(1, 0, 0, 0, '0, '0, 0, 0);
    drive(1, 0, 0, 0, '0, '0, 0, 0);
    check_eq("reset_branch_count", {16'd0, BranchCount}, 32'd0);

    // Correct prediction
    drive(0, 0, 1, 1, 32'h44, 32'h100, 0, 0);
    idle();
    drive(0, 0, 0, 0, '0, '0, 1, 1);
    check_eq("t1_update_valid", {31'd0, UpdateValid}, 32'd1);
    check_eq("t1_update_taken", {31'd0, UpdateTaken}, 32'd1);
    idle();
    check_eq("t1_pulse_once",   {31'd0, UpdateValid}, 32'd0);
    check_eq("t1_branch_count", {16'd0, BranchCount}, 32'd1);
    check_eq("t1_mispred",      {16'd0, MispredictCount}, 32'd0);
    check_eq("t1_flush",        {31'd0, Flush}, 32'd0);

    // Mispredict taken, ID branch during flush must be dropped
    drive(0, 0, 1, 0, 32'h44, 32'h200, 0, 0);
    drive(0, 0, 0, 0, '0, '0, 1, 1);
    check_eq("t2_flush",    {31'd0, Flush}, 32'd1);
    check_eq("t2_redirect", RedirectPC, 32'h200);
    drive(0, 0, 1, 1, 32'h88, 32'h400, 0, 0);
    check_eq("t2_flush_2nd", {31'd0, Flush}, 32'd1);
    check_eq("t2_redirect_2nd", RedirectPC, 32'h200);
    idle();
    check_eq("t2_flush_end", {31'd0, Flush}, 32'd0);
    check_eq("t2_mispred",   {16'd0, MispredictCount}, 32'd1);
    // Queue must be empty: this resolve underflows and does not flush
    drive(0, 0, 0, 0, '0, '0, 1, 0);
    check_eq("t2_underflow", {31'd0, Underflow}, 32'd1);
    check_eq("t2_empty_uv",  {31'd0, UpdateValid}, 32'd1);
    check_eq("t2_empty_fl",  {31'd0, Flush}, 32'd0);

    drive(1, 0, 0, 0, '0, '0, 0, 0);
    check_eq("rst_underflow", {31'd0, Underflow}, 32'd0);

    // Queue full: fifth push overflows, first four return in order
    drive(0, 0, 1, 1, 32'h10, 32'h1000, 0, 0);
    drive(0, 0, 1, 0, 32'h14, 32'h1100, 0, 0);
    drive(0, 0, 1, 1, 32'h18, 32'h1200, 0, 0);
    drive(0, 0, 1, 1, 32'h1c, 32'h1300, 0, 0);
    check_eq("t3_no_ovf_yet", {31'd0, Overflow}, 32'd0);
    drive(0, 0, 1, 0, 32'h20, 32'h1400, 0, 0);
    check_eq("t3_overflow", {31'd0, Overflow}, 32'd1);
    drive(0, 0, 0, 0, '0, '0, 1, 1);
    drive(0, 0, 0, 0, '0, '0, 1, 0);
    drive(0, 0, 0, 0, '0, '0, 1, 1);
    drive(0, 0, 0, 0, '0, '0, 1, 1);
    check_eq("t3_in_order", {16'd0, MispredictCount}, 32'd0);
    check_eq("t3_branches", {16'd0, BranchCount}, 32'd4);

    // Push and pop every cycle across the pointer wrap
    foreach (preds[i]) preds[i] = bit'($urandom_range(1));
    drive(0, 0, 1, preds[0], 32'h500, 32'h600, 0, 0);
    for (int i = 1; i < 11; i++) begin
      drive(0, 0, 1, preds[i], 32'h500 + i * 4, 32'h600 + i * 4, 1, preds[i-1]);
      check_eq("t4_occupancy", 32'(u_dut.u_fifo.o_count), 32'd1);
    end
    drive(0, 0, 0, 0, '0, '0, 1, preds[10]);
    check_eq("t4_in_order", {16'd0, MispredictCount}, 32'd0);
    check_eq("t4_branches", {16'd0, BranchCount}, 32'd15);

    // Stall during RECOVER stretches the flush
    drive(0, 0, 1, 1, 32'h48, 32'h300, 0, 0);
    flush_seen = 0;
    drive(0, 0, 0, 0, '0, '0, 1, 0);
    check_eq("t5_redirect", RedirectPC, 32'h48);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, '0, '0, 0, 0);
    for (int i = 0; i < 10 && Flush; i++) idle();
    check_eq("t5_flush_len", 32'(flush_seen), 32'd5);
    check_eq("t5_flush_off", {31'd0, Flush}, 32'd0);

    // Reset mid-RECOVER
    drive(0, 0, 1, 1, 32'h74, 32'h700, 0, 0);
    drive(0, 0, 0, 0, '0, '0, 1, 0);
    check_eq("t6_flush_on", {31'd0, Flush}, 32'd1);
    drive(1, 0, 0, 0, '0, '0, 0, 0);
    check_eq("t6_flush_rst",    {31'd0, Flush}, 32'd0);
    check_eq("t6_redirect_rst", RedirectPC, 32'd0);
    check_eq("t6_count_rst",    {16'd0, BranchCount}, 32'd0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer end of the branch-prediction loop. Captures each prediction issued in ID and holds it in an in-flight queue until the branch resolves in EX.
- At resolution it compares the prediction with the actual outcome. On a mismatch it raises a pipeline flush with a corrected fetch PC.
- It drives the predictor's training inputs (exists-in-EX, decision-in-EX) and keeps accuracy counters for the processor's debug path.

Parameters:
- DEPTH, 4, in-flight queue entries (power of two, at least 2).
- FLUSH_CYCLES, 2, cycles Flush stays high after a mispredict (at least 1).
- CW, 16, width of the statistics counters.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  reset
- Stall  in  1  pipeline hold; no queue push or pop while high
- BranchInstructExists_ID  in  1  branch in ID this cycle
- Prediction_ID  in  1  predictor output for that branch (1 = taken)
- PCPlus4_ID  in  32  fall-through address
- BranchTarget_ID  in  32  taken address
- BranchInstructExists_EX  in  1  branch resolving in EX
- BranchTaken_EX  in  1  actual outcome
- Flush  out  1  kill IF/ID and younger instructions
- RedirectPC  out  32  corrected fetch address, valid while Flush=1
- UpdateValid  out  1  training strobe to the predictor
- UpdateTaken  out  1  training outcome
- BranchCount  out  CW  resolved branches
- MispredictCount  out  CW  mispredicted branches
- Overflow  out  1  sticky: push attempted while queue full
- Underflow  out  1  sticky: resolve with an empty queue

Behaviour:
- Reset is synchronous, active-high. Reset clears:
  - the queue (empty);
  - state to NORMAL;
  - all outputs to 0, including RedirectPC, both counters and both sticky flags.
  - Reset asserted mid-RECOVER aborts the recovery; Flush is 0 on the next cycle.
- Queue:
  - Circular buffer of {pred, pcplus4, target}, with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
  - An occupancy counter of log2(DEPTH)+1 bits tracks full and empty.
- Push: condition is !Stall, BranchInstructExists_ID and state NORMAL.
  - If the queue is full, the push is dropped and Overflow is set.
- Pop and resolve: condition is !Stall and BranchInstructExists_EX.
  - Pop the head and compare head.pred with BranchTaken_EX.
  - With an empty queue: Underflow is set and the comparison is treated as pred=0 (no redirect address is available). UpdateValid and the counters still act.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- Registered outputs, 1-cycle latency after the resolve edge:
  - UpdateValid=1 and UpdateTaken=BranchTaken_EX for exactly one cycle per resolve.
  - BranchCount+1.
  - On mismatch: MispredictCount+1.
  - Both counters saturate at all-ones.
- On mismatch (non-empty queue):
  - Flush=1 and RedirectPC = BranchTaken_EX ? head.target : head.pcplus4.
  - The whole queue is cleared; a push in the same cycle is discarded.
  - State goes to RECOVER with counter = FLUSH_CYCLES-1.
- State machine:
  - NORMAL: Flush=0. A mismatch moves to RECOVER.
  - RECOVER: Flush=1 and RedirectPC is held. No pushes are accepted. If counter==0, return to NORMAL next cycle; otherwise decrement.
  - The counter holds while Stall=1, so Flush stays high through the stall.
  - An EX resolve during RECOVER is still trained and counted but never re-flushes: the queue is empty, so Underflow is not raised for it.
- Stall has no effect on the sticky flags or on registered outputs already in flight.

Decomposition:
- Shared package holds:
  - the queue entry struct {pred, pcplus4[31:0], target[31:0]};
  - the state enum {NORMAL, RECOVER};
  - PC width constant 32.
- One natural sub-module: bru_pred_fifo (parameterised circular buffer with push, pop, clear, full, empty and count).
- The FSM, compare logic and counters stay in the top module.

Test Plan:
- Correct prediction: push pred=1, target=0x100, pcplus4=0x44; resolve taken=1 two cycles later -> UpdateValid pulse with UpdateTaken=1, BranchCount=1, MispredictCount=0, Flush stays 0.
- Mispredict taken: push pred=0, pcplus4=0x44, target=0x200; resolve taken=1 -> next cycle Flush=1 and RedirectPC=0x200 for 2 cycles; MispredictCount=1; queue empty afterwards; an ID branch during flush is not queued.
- Queue full: DEPTH=4, push 5 branches with no resolve -> Overflow=1 after the 5th; resolving 4 branches returns the first 4 entries' predictions in order.
- Simultaneous push/pop with wrap: run 10 cycles of push and pop every cycle -> occupancy constant and predictions returned in order across the pointer wrap.
- Stall during RECOVER: mispredict, then Stall=1 for 3 cycles -> Flush stays high for 3+2 cycles total; RedirectPC unchanged.
- Reset mid-RECOVER and empty-queue resolve: Reset during Flush -> all outputs 0 next cycle. A resolve with an empty queue -> Underflow=1, UpdateValid pulse, Flush=0 if taken=0.
